frame_commutator: RTL and testbench

FRAME_COMMUTATOR -- requirements
Module: frame_commutator

---
 rtl/frame_commutator.sv | 99 +++++++++
 tb/tb_frame_commutator.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/frame_commutator.sv
// Frame commutator: scatters a serial word stream into per-channel slots and
// presents each completed frame, masked by the channel enables it was built with.
module frame_commutator #(
  parameter  int WIDTH  = 16,
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_sof,
  output logic [WIDTH-1:0]  out_data [NUM_CH-1:0],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NUM_CH-1:0] out_mask,
  output logic [CH_W-1:0]   cur_ch,
  output logic              err_short
);

  // Handshake: a word moves on in_valid && in_ready, a frame on out_valid && out_ready.
  typedef enum logic {IDLE, FILL} state_t;

  state_t            state;
  logic [CH_W-1:0]   ptr;
  logic [NUM_CH-1:0] fmask;
  logic [WIDTH-1:0]  stage [NUM_CH-1:0];

  logic              accept, pop, start, would_complete;
  logic [NUM_CH-1:0] wmask;
  logic [CH_W-1:0]   wptr;

  function automatic logic [CH_W-1:0] lowest(input logic [NUM_CH-1:0] m);
    lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (m[i]) lowest = CH_W'(i);
  endfunction

  function automatic logic [CH_W-1:0] next_above(input logic [NUM_CH-1:0] m,
                                                 input logic [CH_W-1:0] p);
    next_above = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (m[i] && i > int'(p)) next_above = CH_W'(i);
  endfunction

  function automatic logic any_above(input logic [NUM_CH-1:0] m,
                                     input logic [CH_W-1:0] p);
    any_above = 1'b0;
    for (int i = 0; i < NUM_CH; i++) if (m[i] && i > int'(p)) any_above = 1'b1;
  endfunction

  // An sof word, or any word while idle, restarts on the live enable mask.
  always_comb begin
    start          = (state == IDLE) || in_sof;
    wmask          = start ? ch_en : fmask;
    wptr           = start ? lowest(ch_en) : ptr;
    would_complete = (wmask != '0) && !any_above(wmask, wptr);
    in_ready       = !(would_complete && out_valid && !out_ready);
    accept         = in_valid && in_ready;
    pop            = out_valid && out_ready;
    cur_ch         = (state == FILL) ? ptr : lowest(ch_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      fmask     <= '0;
      out_valid <= 1'b0;
      out_mask  <= '0;
      err_short <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        stage[i]    <= '0;
        out_data[i] <= '0;
      end
    end else begin
      err_short <= accept && in_sof && (state == FILL);
      if (pop) out_valid <= 1'b0;
      if (accept) begin
        if (wmask == '0) begin
          state <= IDLE;
        end else if (would_complete) begin
          for (int i = 0; i < NUM_CH; i++)
            out_data[i] <= !wmask[i] ? '0 :
                           (i == int'(wptr)) ? in_data : stage[i];
          out_mask  <= wmask;
          out_valid <= 1'b1;
          state     <= IDLE;
        end else begin
          stage[wptr] <= in_data;
          ptr         <= next_above(wmask, wptr);
          fmask       <= wmask;
          state       <= FILL;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_commutator.sv
// Bench for frame_commutator: directed scenarios plus random traffic, all
// checked against a channel-list model of frame assembly.
module tb_frame_commutator;
  localparam int WIDTH  = 16;
  localparam int NUM_CH = 4;
  localparam int FW     = NUM_CH * WIDTH + NUM_CH;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] ch_en = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data = '0;
  logic              in_sof = 1'b0;
  logic [WIDTH-1:0]  out_data [NUM_CH-1:0];
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [NUM_CH-1:0] out_mask;
  logic [1:0]        cur_ch;
  logic              err_short;

  frame_commutator #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_mask(out_mask), .cur_ch(cur_ch), .err_short(err_short)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: frame = ordered list of channels still to fill; expected frames queued.
  logic [FW-1:0]    exp_q[$];
  int               m_order[$];
  logic             m_busy = 1'b0;
  logic [NUM_CH-1:0] m_fm = '0;
  logic [WIDTH-1:0] m_stage [NUM_CH];
  logic             m_err = 1'b0;

  task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] dut_frame();
    logic [FW-1:0] f;
    f = '0;
    f[FW-1 -: NUM_CH] = out_mask;
    for (int i = 0; i < NUM_CH; i++) f[i*WIDTH +: WIDTH] = out_data[i];
    return f;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_order.delete();
    m_busy = 1'b0;
    m_fm   = '0;
    m_err  = 1'b0;
  endtask

  task automatic check_outputs();
    chk("out_valid", FW'(out_valid), FW'(exp_q.size() != 0));
    chk("err_short", FW'(err_short), FW'(m_err));
    if (exp_q.size() != 0) chk("frame", dut_frame(), exp_q[0]);
  endtask

  // One clock cycle: drive, check pre-edge outputs, advance model, check post-edge.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic s,
                      input logic [NUM_CH-1:0] en, input logic r);
    int exp_ch;
    logic wc, m_ready, acc, m_pop;
    logic [FW-1:0] f;
    in_valid = v; in_data = d; in_sof = s; ch_en = en; out_ready = r;
    #1;
    exp_ch = 0;
    if (m_busy) exp_ch = m_order[0];
    else for (int i = NUM_CH - 1; i >= 0; i--) if (en[i]) exp_ch = i;
    if (!m_busy || s) wc = ($countones(en) == 1);
    else              wc = (m_order.size() == 1);
    m_ready = !(wc && exp_q.size() != 0 && !r);
    chk("in_ready", FW'(in_ready), FW'(m_ready));
    chk("cur_ch", FW'(cur_ch), FW'(exp_ch));
    acc   = v && m_ready;
    m_pop = (exp_q.size() != 0) && r;
    @(posedge clk);
    m_err = 1'b0;
    if (m_pop) void'(exp_q.pop_front());
    if (acc) begin
      if (m_busy && s) m_err = 1'b1;
      if (!m_busy || s) begin
        m_order.delete();
        for (int i = 0; i < NUM_CH; i++) if (en[i]) m_order.push_back(i);
        m_fm   = en;
        m_busy = 1'b0;
      end
      if (m_order.size() != 0) begin
        m_stage[m_order.pop_front()] = d;
        if (m_order.size() == 0) begin
          f = '0;
          f[FW-1 -: NUM_CH] = m_fm;
          for (int i = 0; i < NUM_CH; i++) if (m_fm[i]) f[i*WIDTH +: WIDTH] = m_stage[i];
          exp_q.push_back(f);
          m_busy = 1'b0;
        end else begin
          m_busy = 1'b1;
        end
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic check_reset_state();
    chk("rst_out_valid", FW'(out_valid), '0);
    chk("rst_out_mask", FW'(out_mask), '0);
    chk("rst_err_short", FW'(err_short), '0);
    chk("rst_in_ready", FW'(in_ready), FW'(1'b1));
    for (int i = 0; i < NUM_CH; i++) chk("rst_out_data", FW'(out_data[i]), '0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full mask, consumer always ready
    step(1, 16'h000A, 0, 4'b1111, 1);
    step(1, 16'h000B, 0, 4'b1111, 1);
    step(1, 16'h000C, 0, 4'b1111, 1);
    step(1, 16'h000D, 0, 4'b1111, 1);
    chk("seq_frame", dut_frame(), {4'b1111, 16'h000D, 16'h000C, 16'h000B, 16'h000A});
    step(0, 16'h0, 0, 4'b1111, 1);

    // Sparse mask 1010
    step(1, 16'h0001, 0, 4'b1010, 1);
    step(1, 16'h0002, 0, 4'b1010, 1);
    chk("sparse_frame", dut_frame(), {4'b1010, 16'h0002, 16'h0000, 16'h0001, 16'h0000});
    step(0, 16'h0, 0, 4'b1010, 1);

    // Backpressure: second frame blocked on its last word until a pop
    for (int k = 0; k < 8; k++) step(1, 16'h0100 + 16'(k), 0, 4'b1111, 0);
    step(1, 16'h0107, 0, 4'b1111, 0);
    step(1, 16'h0107, 0, 4'b1111, 1);
    chk("bp_frame2", dut_frame(), {4'b1111, 16'h0107, 16'h0106, 16'h0105, 16'h0104});
    step(0, 16'h0, 0, 4'b1111, 1);

    // Short frame interrupted by sof
    step(1, 16'h0011, 0, 4'b1111, 1);
    step(1, 16'h0022, 0, 4'b1111, 1);
    step(1, 16'h0055, 1, 4'b1111, 1);
    chk("sof_err", FW'(err_short), FW'(1'b1));
    for (int k = 0; k < 3; k++) step(1, 16'h0060 + 16'(k), 0, 4'b1111, 1);
    chk("sof_frame", dut_frame(), {4'b1111, 16'h0062, 16'h0061, 16'h0060, 16'h0055});

    // No channels enabled: words dropped
    for (int k = 0; k < 3; k++) step(1, 16'h0abc, 0, 4'b0000, 1);

    // Single channel: every word is a frame
    for (int k = 0; k < 3; k++) step(1, 16'h0700 + 16'(k), 0, 4'b0100, 1);

    // Reset mid-frame, asynchronous
    step(1, 16'h0201, 0, 4'b1111, 1);
    step(1, 16'h0202, 0, 4'b1111, 0);
    step(0, 16'h0, 0, 4'b1111, 0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_state();
    chk("rst_cur_ch", FW'(cur_ch), '0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(1, 16'h0300 + 16'(k), 0, 4'b1111, 1);
    chk("post_rst_frame", dut_frame(), {4'b1111, 16'h0303, 16'h0302, 16'h0301, 16'h0300});

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      logic [NUM_CH-1:0] en;
      en = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : 4'b1111;
      if ($urandom_range(0, 7) == 0) en = 4'b1001;
      step($urandom_range(0, 3) != 0, WIDTH'($urandom), $urandom_range(0, 9) == 0,
           en, $urandom_range(0, 4) < 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
